ili934x_rect_filler: RTL and testbench

//  Rectangle/pattern pixel source feeding the window + pixel-stream interface of ili934x_driver.

---
 rtl/ili934x_rect_filler.sv | 184 ++++++++++++++++++
 tb/tb_ili934x_rect_filler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ili934x_rect_filler.sv
// Rectangle/pattern pixel source for the ili934x_driver window + pixel-stream interface.
// Clamps a fill request to the panel, programs the window, then streams w*h RGB565 pixels in raster order.
module ili934x_rect_filler #(
  parameter int X_RES     = 240,
  parameter int Y_RES     = 320,
  parameter int CELL_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_x0,
  input  logic [15:0] req_y0,
  input  logic [15:0] req_x1,
  input  logic [15:0] req_y1,
  input  logic [1:0]  req_mode,
  input  logic [15:0] req_color_a,
  input  logic [15:0] req_color_b,
  input  logic        abort,
  output logic        win_set_stb,
  output logic [15:0] win_x0,
  output logic [15:0] win_y0,
  output logic [15:0] win_x1,
  output logic [15:0] win_y1,
  input  logic        drv_busy,
  output logic        stream_start,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        fill_done,
  output logic        req_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WIN,
    S_WAITW,
    S_START,
    S_STREAM,
    S_DONE
  } state_t;

  localparam logic [15:0] X_MAX = 16'(X_RES - 1);
  localparam logic [15:0] Y_MAX = 16'(Y_RES - 1);

  state_t      state;
  logic [1:0]  fill_mode;
  logic [15:0] color_a;
  logic [15:0] color_b;
  logic [16:0] remaining;
  logic [15:0] cx;
  logic [15:0] cy;
  logic        wait_first;

  logic [15:0] clx0, cly0, clx1, cly1;
  logic        rect_empty;
  logic [16:0] span_w, span_h;
  logic        last_col;
  logic [15:0] nx, ny;

  assign clx0 = (req_x0 > X_MAX) ? X_MAX : req_x0;
  assign clx1 = (req_x1 > X_MAX) ? X_MAX : req_x1;
  assign cly0 = (req_y0 > Y_MAX) ? Y_MAX : req_y0;
  assign cly1 = (req_y1 > Y_MAX) ? Y_MAX : req_y1;
  assign rect_empty = (clx0 > clx1) || (cly0 > cly1);

  assign span_w = 17'(win_x1 - win_x0) + 17'd1;
  assign span_h = 17'(win_y1 - win_y0) + 17'd1;

  // Raster walk: cx runs fastest and wraps at the right edge of the window.
  assign last_col = (cx == (win_x1 - win_x0));
  assign nx       = last_col ? 16'd0 : cx + 16'd1;
  assign ny       = last_col ? cy + 16'd1 : cy;

  assign req_ready = (state == S_IDLE) && init_done;
  assign busy      = (state != S_IDLE);

  function automatic logic [15:0] pattern(input logic xb, input logic yb);
    logic use_b;
    case (fill_mode)
      2'd1:    use_b = xb ^ yb;
      2'd2:    use_b = yb;
      default: use_b = 1'b0;
    endcase
    return use_b ? color_b : color_a;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      fill_mode    <= 2'd0;
      color_a      <= 16'd0;
      color_b      <= 16'd0;
      win_x0       <= 16'd0;
      win_y0       <= 16'd0;
      win_x1       <= 16'd0;
      win_y1       <= 16'd0;
      remaining    <= 17'd0;
      cx           <= 16'd0;
      cy           <= 16'd0;
      wait_first   <= 1'b0;
      win_set_stb  <= 1'b0;
      stream_start <= 1'b0;
      fill_done    <= 1'b0;
      req_err      <= 1'b0;
      pix_valid    <= 1'b0;
      pix_data     <= 16'd0;
    end else begin
      win_set_stb  <= 1'b0;
      stream_start <= 1'b0;
      fill_done    <= 1'b0;
      req_err      <= 1'b0;
      // Abort outranks everything, including a final transfer in the same cycle.
      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        pix_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_valid && req_ready) begin
              fill_mode <= req_mode;
              color_a   <= req_color_a;
              color_b   <= req_color_b;
              if (rect_empty) begin
                req_err <= 1'b1;
              end else begin
                win_x0      <= clx0;
                win_y0      <= cly0;
                win_x1      <= clx1;
                win_y1      <= cly1;
                win_set_stb <= 1'b1;
                state       <= S_WIN;
              end
            end
          end
          S_WIN: begin
            remaining  <= span_w * span_h;
            wait_first <= 1'b1;
            state      <= S_WAITW;
          end
          S_WAITW: begin
            // The driver may not have raised busy yet in the cycle after the strobe.
            if (wait_first) begin
              wait_first <= 1'b0;
            end else if (!drv_busy) begin
              stream_start <= 1'b1;
              state        <= S_START;
            end
          end
          S_START: begin
            cx        <= 16'd0;
            cy        <= 16'd0;
            pix_valid <= 1'b1;
            pix_data  <= pattern(1'b0, 1'b0);
            state     <= S_STREAM;
          end
          S_STREAM: begin
            if (pix_valid && pix_ready) begin
              if (remaining == 17'd1) begin
                pix_valid <= 1'b0;
                fill_done <= 1'b1;
                state     <= S_DONE;
              end else begin
                remaining <= remaining - 17'd1;
                cx        <= nx;
                cy        <= ny;
                pix_data  <= pattern(nx[CELL_LOG2], ny[CELL_LOG2]);
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ili934x_rect_filler.sv
// Randomized bench for ili934x_rect_filler against a raster/pattern reference model.
module tb_ili934x_rect_filler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
  logic [1:0]  req_mode = '0;
  logic [15:0] req_color_a = '0, req_color_b = '0;
  logic        abort = 1'b0;
  logic        win_set_stb;
  logic [15:0] win_x0, win_y0, win_x1, win_y1;
  logic        drv_busy = 1'b0;
  logic        stream_start;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic        fill_done;
  logic        req_err;
  logic        busy;

  ili934x_rect_filler dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .req_mode(req_mode), .req_color_a(req_color_a), .req_color_b(req_color_b),
    .abort(abort), .win_set_stb(win_set_stb),
    .win_x0(win_x0), .win_y0(win_y0), .win_x1(win_x1), .win_y1(win_y1),
    .drv_busy(drv_busy), .stream_start(stream_start),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .fill_done(fill_done), .req_err(req_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state and observed-event counters
  logic [15:0] exp_q[$];
  int          exp_total;
  int          xfers, n_stb, n_start, n_done, n_err;
  logic [15:0] cap_x0, cap_y0, cap_x1, cap_y1;
  bit          stall_chk = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_dat = '0;
  int          rdy_mode = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (win_set_stb) begin
        n_stb++;
        cap_x0 = win_x0; cap_y0 = win_y0; cap_x1 = win_x1; cap_y1 = win_y1;
      end
      if (stream_start) n_start++;
      if (fill_done) n_done++;
      if (req_err) n_err++;
      if (stall_chk && prev_stall) begin
        check("stall_valid", pix_valid, 1);
        check("stall_data", pix_data, prev_dat);
      end
      prev_stall = pix_valid && !pix_ready;
      prev_dat   = pix_data;
      if (pix_valid && pix_ready) begin
        xfers++;
        if (exp_q.size() == 0) check("pix_count", xfers, exp_total);
        else check("pix_data", pix_data, exp_q.pop_front());
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Background input noise: random pix_ready when enabled, occasional drv_busy
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) pix_ready = 1'($urandom_range(0, 1));
      drv_busy = ($urandom_range(0, 3) == 0);
    end
  end

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Builds the expected pixel sequence and returns the clamped window.
  task automatic build_model(input int x0, y0, x1, y1, input int mode, input logic [15:0] a, b,
                             output int ex0, ey0, ex1, ey1);
    int w, h, sel;
    ex0 = clampv(x0, 239); ex1 = clampv(x1, 239);
    ey0 = clampv(y0, 319); ey1 = clampv(y1, 319);
    exp_q.delete();
    if (ex0 <= ex1 && ey0 <= ey1) begin
      w = ex1 - ex0 + 1;
      h = ey1 - ey0 + 1;
      for (int r = 0; r < h; r++) begin
        for (int c = 0; c < w; c++) begin
          if (mode == 1) sel = ((c / 8) % 2) ^ ((r / 8) % 2);
          else if (mode == 2) sel = (r / 8) % 2;
          else sel = 0;
          exp_q.push_back(sel ? b : a);
        end
      end
    end
    exp_total = exp_q.size();
    xfers = 0; n_stb = 0; n_start = 0; n_done = 0; n_err = 0;
  endtask

  task automatic issue_req(input int x0, y0, x1, y1, input int mode, input logic [15:0] a, b);
    @(posedge clk);
    #1;
    req_x0 = 16'(x0); req_y0 = 16'(y0); req_x1 = 16'(x1); req_y1 = 16'(y1);
    req_mode = 2'(mode); req_color_a = a; req_color_b = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic run_fill(input string tag, input int x0, y0, x1, y1, input int mode,
                          input logic [15:0] a, b, input int rmode, input int budget);
    int ex0, ey0, ex1, ey1;
    build_model(x0, y0, x1, y1, mode, a, b, ex0, ey0, ex1, ey1);
    rdy_mode  = rmode;
    if (rmode == 0) pix_ready = 1'b1;
    stall_chk = 1'b1;
    issue_req(x0, y0, x1, y1, mode, a, b);
    for (int i = 0; i < budget && n_done == 0 && n_err == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    if (exp_total == 0) begin
      check({tag, "_req_err"}, n_err, 1);
      check({tag, "_no_stb"}, n_stb, 0);
      check({tag, "_no_start"}, n_start, 0);
    end else begin
      check({tag, "_xfers"}, xfers, exp_total);
      check({tag, "_done"}, n_done, 1);
      check({tag, "_stb"}, n_stb, 1);
      check({tag, "_start"}, n_start, 1);
      check({tag, "_wx0"}, cap_x0, ex0);
      check({tag, "_wy0"}, cap_y0, ey0);
      check({tag, "_wx1"}, cap_x1, ex1);
      check({tag, "_wy1"}, cap_y1, ey1);
    end
    check({tag, "_idle"}, busy, 0);
    stall_chk = 1'b0;
    rdy_mode  = 0;
  endtask

  initial begin
    int ex0, ey0, ex1, ey1;
    int x0, y0;

    // Reset values
    #12;
    check("rst_ready_lo", req_ready, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_win_x1", win_x1, 0);
    check("rst_stb", win_set_stb, 0);
    check("rst_done", fill_done, 0);
    init_done = 1'b1;
    #1;
    check("rst_ready_hi", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // No accept while init is incomplete
    init_done = 1'b0;
    build_model(0, 0, 3, 3, 0, 16'h1234, 16'h0, ex0, ey0, ex1, ey1);
    @(posedge clk); #1;
    req_x0 = 0; req_y0 = 0; req_x1 = 3; req_y1 = 3; req_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("noinit_busy", busy, 0);
    check("noinit_stb", n_stb, 0);
    init_done = 1'b1;

    run_fill("full", 0, 0, 239, 319, 0, 16'hF800, 16'h0000, 0, 80000);
    run_fill("checker", 0, 0, 15, 15, 1, 16'h0000, 16'hFFFF, 0, 1000);
    run_fill("clamp", 230, 310, 400, 400, 0, 16'h07E0, 16'h001F, 0, 1000);
    run_fill("empty", 10, 5, 9, 20, 0, 16'h07E0, 16'h001F, 0, 50);
    run_fill("bp", 20, 30, 22, 31, 2, 16'hAAAA, 16'h5555, 1, 500);
    run_fill("single", 7, 9, 7, 9, 1, 16'h1357, 16'h2468, 1, 200);
    run_fill("stripes", 100, 4, 103, 21, 2, 16'h0F0F, 16'hF0F0, 1, 1000);

    for (int k = 0; k < 8; k++) begin
      x0 = $urandom_range(2, 250);
      y0 = $urandom_range(2, 330);
      run_fill("rand", x0, y0, x0 + $urandom_range(0, 12) - 2, y0 + $urandom_range(0, 12) - 2,
               $urandom_range(0, 3), 16'($urandom), 16'($urandom), 1, 1000);
    end

    // Abort after 10 transfers
    build_model(0, 0, 19, 19, 0, 16'hBEEF, 16'h0, ex0, ey0, ex1, ey1);
    pix_ready = 1'b1;
    issue_req(0, 0, 19, 19, 0, 16'hBEEF, 16'h0);
    for (int i = 0; i < 200 && xfers < 10; i++) @(posedge clk);
    #1;
    pix_ready = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", pix_valid, 0);
    check("abort_ready", req_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", n_done, 0);
    check("abort_xfers", xfers, 10);

    // Asynchronous reset mid-stream, then a normal fill
    build_model(0, 0, 19, 19, 1, 16'h1111, 16'h2222, ex0, ey0, ex1, ey1);
    pix_ready = 1'b1;
    issue_req(0, 0, 19, 19, 1, 16'h1111, 16'h2222);
    for (int i = 0; i < 200 && xfers < 5; i++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", pix_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_win_x1", win_x1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_fill("post_rst", 50, 60, 58, 66, 1, 16'h0001, 16'h8000, 1, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
